// File: rtl/isa_test_monitor.sv
// Snoops CPU status-register writes and tracks a per-channel test verdict with a shared timeout.
// Optional per-channel status word capture is enabled by defining ISA_MON_CODE_CAPTURE_EN.
module isa_test_monitor #(
  parameter int          NUM_CH    = 1,
  parameter int unsigned TIMEOUT   = 10000,
  parameter logic [29:0] BASE_ADDR = 30'h3FFFFF00,
  parameter logic [31:0] PASS_CODE = 32'h55,
  parameter logic [31:0] FAIL_CODE = 32'hAA
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [29:0]           addr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            we,
  input  logic [NUM_CH-1:0]     halt,
  output logic [3*NUM_CH-1:0]   ch_state,
  output logic [31:0]           cycles,
  output logic                  done,
  output logic                  all_pass,
  output logic [32*NUM_CH-1:0]  code
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    PASS    = 3'd1,
    FAIL    = 3'd2,
    ERROR   = 3'd3,
    TIMEOUT_ST = 3'd4
  } state_t;

  state_t            state      [NUM_CH];
  state_t            state_next [NUM_CH];
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] running;
  logic              any_run;
  logic              timeout_hit;

  // Only full-word writes to a channel's own status address count as a verdict.
  always_comb begin
    wr_hit  = '0;
    running = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      wr_hit[k]  = (we == 4'b1111) && (addr == BASE_ADDR + 30'(k));
      running[k] = (state[k] == RUN);
    end
    any_run     = |running;
    timeout_hit = any_run && (cycles == 32'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) state[k] <= RUN;
      cycles <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) state[k] <= state_next[k];
      if (any_run) cycles <= cycles + 32'd1;
    end
  end

  // Priority inside RUN: status write, then halt, then timeout.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      state_next[k] = state[k];
      if (state[k] == RUN) begin
        if (wr_hit[k]) begin
          if (wdata == PASS_CODE)      state_next[k] = PASS;
          else if (wdata == FAIL_CODE) state_next[k] = FAIL;
          else                         state_next[k] = ERROR;
        end else if (halt[k]) begin
          state_next[k] = ERROR;
        end else if (timeout_hit) begin
          state_next[k] = TIMEOUT_ST;
        end
      end
    end
  end

  always_comb begin
    ch_state = '0;
    all_pass = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_state[3*k +: 3] = state[k];
      if (state[k] != PASS) all_pass = 1'b0;
    end
    done = ~any_run;
  end

`ifdef ISA_MON_CODE_CAPTURE_EN
  logic [31:0] code_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) code_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        if (state[k] == RUN && wr_hit[k]) code_q[k] <= wdata;
    end
  end

  always_comb begin
    code = '0;
    for (int k = 0; k < NUM_CH; k++) code[32*k +: 32] = code_q[k];
  end
`else
  assign code = '0;
`endif

endmodule
